// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding and frame geometry.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  // 47.9 MHz core clock at 115200 baud
  localparam int CORE_DIVISOR = 416;
  localparam int FRAME_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with explicit occupancy count.
// A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count == '0);
  assign full = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead FIFO.
// Drives cts_n from FIFO occupancy with hysteresis.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DIVISOR = CORE_DIVISOR,
  parameter int DEPTH_LOG2 = 4,
  parameter int CTS_HIGH = 12,
  parameter int CTS_LOW = 4
) (
  input  logic                  clk_core,
  input  logic                  reset,
  input  logic                  rx,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ack,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  clr_err,
  output logic                  cts_n
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [15:0] HALF = 16'(DIVISOR / 2 - 1);
  localparam logic [15:0] RELOAD = 16'(DIVISOR - 1);
  localparam logic [2:0] LAST = 3'(FRAME_BITS - 1);

  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_prev;
  state_t                state;
  state_t                state_n;
  logic [15:0]           baud_cnt;
  logic [15:0]           baud_n;
  logic [2:0]            idx;
  logic [2:0]            idx_n;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_n;
  logic                  push;
  logic                  stop_bad;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;
  logic [CW-1:0]         count_n;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state <= IDLE;
      baud_cnt <= '0;
      idx <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      idx <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n = baud_cnt;
    idx_n = idx;
    shreg_n = shreg;
    push = 1'b0;
    stop_bad = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          baud_n = HALF;
          state_n = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            baud_n = RELOAD;
            idx_n = '0;
            state_n = DATA;
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          shreg_n = {rx_s, shreg[FRAME_BITS-1:1]};
          baud_n = RELOAD;
          idx_n = idx + 3'd1;
          if (idx == LAST) state_n = STOP;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          if (rx_s) begin
            push = 1'b1;
            state_n = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n = BREAK;
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      // a held-low line must not retrigger framing
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH(FRAME_BITS),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk(clk_core),
    .reset(reset),
    .push(push),
    .wr_data(shreg),
    .pop(rd_ack),
    .rd_data(rd_data),
    .count(count),
    .full(full),
    .empty(empty)
  );

  assign rd_valid = !empty;
  assign rd_en = rd_ack && !empty;
  assign wr_en = push && (!full || rd_en);
  assign count_n = count + CW'(wr_en) - CW'(rd_en);

  always_ff @(posedge clk_core) begin
    if (reset) begin
      overrun <= 1'b0;
      frame_err <= 1'b0;
      cts_n <= 1'b0;
    end else begin
      if (push && !wr_en) overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (stop_bad) frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (count_n >= CW'(CTS_HIGH)) cts_n <= 1'b1;
      else if (count_n <= CW'(CTS_LOW)) cts_n <= 1'b0;
    end
  end

endmodule
